axi_rd_burst_ctrl: RTL and testbench
====================================

Name: axi_rd_burst_ctrl

Overview:
- AXI4 read-channel master controller that turns one command (start address, total beat count) into a sequence of legal INCR read bursts.
- Each burst is capped at MAX_BURST beats and never crosses a 4 KiB boundary.
- Returned R beats are forwarded onto a valid/ready output stream.
- Sits between a local engine (e.g. accelerator loader or DMA front-end) and the flat-signal side of the SoC AXI interface, with one burst outstanding at a time.

Parameters:
- ADDR_W, 48, AXI address width.
- DATA_W, 64, AXI data width; power of two, 32..512.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on ar_id_o.
- MAX_BURST, 256, maximum beats per burst; power of two, 1..256.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_addr_i  in  ADDR_W  start byte address, aligned to DATA_W/8.
- cmd_beats_i  in  32  total beats requested.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle pulse at command completion.
- err_o  out  1  sticky error; cleared on next command accept.
- ar_valid_o  out  1  AR valid.
- ar_ready_i  in  1  AR ready.
- ar_id_o  out  ID_W  equals AXI_ID.
- ar_addr_o  out  ADDR_W  burst start address.
- ar_len_o  out  8  beats-1.
- ar_size_o  out  3  log2(DATA_W/8).
- ar_burst_o  out  2  constant 2'b01 (INCR).
- r_valid_i  in  1  R valid.
- r_ready_o  out  1  R ready.
- r_data_i  in  DATA_W  R data.
- r_resp_i  in  2  R response.
- r_last_i  in  1  R last.
- out_valid_o  out  1  stream valid.
- out_ready_i  in  1  stream ready.
- out_data_o  out  DATA_W  stream data, equals r_data_i.
- out_last_o  out  1  final beat of the whole command.

Behaviour:
- Reset (rst_i high at a clock edge), taking effect from the next cycle:
  - FSM goes to IDLE.
  - All outputs 0, except ar_size_o and ar_burst_o, which are constant.
  - Address, remaining-beat and beat counters are cleared.
- Reset mid-transfer: the command is abandoned immediately, with no done pulse. Any in-flight AXI burst is the system's responsibility; the controller simply re-enters IDLE.
- FSM states: IDLE, ISSUE, DATA, FIN.
- IDLE:
  - cmd_ready_o=1.
  - On accept: latch addr into addr_q and beats into rem_q; clear err_o.
  - If beats==0, go to FIN; otherwise go to ISSUE.
- ISSUE:
  - ar_valid_o=1.
  - ar_addr_o=addr_q.
  - len = min(rem_q, MAX_BURST, (4096 - addr_q[11:0]) >> log2(DATA_W/8)).
  - ar_len_o = len-1.
  - AR payload is stable while ar_valid_o && !ar_ready_i. ar_valid_o is never dropped before the handshake.
  - On handshake: latch len into burst_q; addr_q += len*(DATA_W/8) (the addition wraps at ADDR_W); rem_q -= len; go to DATA.
- DATA:
  - r_ready_o = out_ready_i.
  - out_valid_o = r_valid_i.
  - out_data_o = r_data_i.
  - Pass-through is combinational, with zero added latency.
  - beat_q counts accepted beats.
  - out_last_o = r_last_i && rem_q==0.
  - r_resp_i != 2'b00 on any accepted beat sets err_o.
  - An accepted r_last_i with beat_q+1 != burst_q sets err_o (protocol error).
  - A beat with beat_q+1 == burst_q and no r_last also sets err_o; the controller still waits for r_last.
  - The burst ends only on an accepted r_last_i. Then clear beat_q; go to FIN if rem_q==0, otherwise ISSUE.
- FIN:
  - done_o=1 for exactly one cycle, then IDLE.
  - busy_o = (state != IDLE).
- Timing and ordering:
  - Minimum gap between bursts is one cycle (AR is issued in the cycle after the last R).
  - Commands are never overlapped; cmd_ready_o=0 outside IDLE.
- Width rules:
  - rem_q is 32 bits.
  - The 4 KiB term is computed with 13 bits so that a page-aligned address yields 4096/BPB.

Optional Feature:
- Macro: AXI_RD_BURST_ABORT_ON_ERR_EN.
- When defined:
  - After the burst in which err_o became set completes (r_last accepted), the controller goes to FIN without issuing further bursts.
  - out_last_o is asserted on that r_last beat.
  - rem_q is left non-zero.
- When undefined: errors are recorded in err_o only, and the full command is always executed.

Test Plan:
1. DATA_W=64, cmd addr=0x1000, beats=16, ar_ready and R always ready -> one AR with addr 0x1000, len 15; 16 beats out; out_last on the 16th beat; done_o pulses in the cycle after it; err_o=0.
2. addr=0x0FF0, beats=8 -> AR0 addr 0x0FF0 len 1; AR1 addr 0x1000 len 5 (4 KiB split); out_last only on the 8th beat.
3. MAX_BURST=256, addr=0x0, beats=600 -> ARs with len 255, 255, 87 at addrs 0x0, 0x800, 0x1000; out_ready toggled 50% -> no data lost or duplicated; r_ready_o mirrors out_ready_i.
4. beats=0 -> cmd accepted; no AR issued; done_o pulses within 2 cycles.
5. 4-beat burst with r_resp=2'b10 on beat 2, and separately r_last early on beat 3 -> err_o=1 and held until the next command accept.
   - Macro defined with beats=1024: ARs stop after the erroring burst; done_o pulses.
   - Macro undefined: all 4 ARs are issued.
6. rst_i asserted in DATA mid-burst -> the next cycle shows IDLE, all outputs 0, cmd_ready_o=1, no done_o pulse; a new command then runs normally.

Source files
------------

// File: rtl/axi_rd_burst_ctrl.sv
// axi_rd_burst_ctrl
//   AXI4 read-channel master controller. Splits one command (start address,
//   beat count) into INCR bursts of at most MAX_BURST beats that never cross
//   a 4 KiB page, with one burst outstanding at a time. R beats pass through
//   combinationally to a valid/ready output stream.
//
//   Optional feature macro: AXI_RD_BURST_ABORT_ON_ERR_EN
//     defined   : once err_o is set, the command finishes at the end of the
//                 current burst (out_last_o marks that r_last beat).
//     undefined : errors are only recorded; the whole command always runs.
//
// Ports
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake
//   cmd_addr_i, cmd_beats_i   start byte address (beat aligned), total beats
//   busy_o, done_o, err_o     in progress, completion pulse, sticky error
//   ar_*                      AXI AR channel (constant ID, SIZE, INCR)
//   r_*                       AXI R channel
//   out_valid_o/out_ready_i   output stream handshake
//   out_data_o, out_last_o    stream payload; last = final beat of command
module axi_rd_burst_ctrl #(
    parameter int unsigned ADDR_W    = 48,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned AXI_ID    = 0,
    parameter int unsigned MAX_BURST = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_beats_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [ID_W-1:0]   ar_id_o,
    output logic [ADDR_W-1:0] ar_addr_o,
    output logic [7:0]        ar_len_o,
    output logic [2:0]        ar_size_o,
    output logic [1:0]        ar_burst_o,
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [DATA_W-1:0] r_data_i,
    input  logic [1:0]        r_resp_i,
    input  logic              r_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    localparam int unsigned BPB    = DATA_W / 8;
    localparam int unsigned SIZE   = $clog2(BPB);
    localparam logic [8:0]  LP_MAX = 9'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_FIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_rem;
    logic [8:0]        r_burst;
    logic [8:0]        r_beat;
    logic              r_err;

    logic [12:0]       w_page_bytes;
    logic [12:0]       w_page_beats;
    logic [8:0]        w_cap;
    logic [8:0]        w_len;
    logic              w_cmd_acc;
    logic              w_ar_hs;
    logic              w_r_acc;
    logic              w_beat_err;
    logic              w_end_cmd;

    // 13-bit page term so a page-aligned address yields a full 4096/BPB
    assign w_page_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_page_beats = w_page_bytes >> SIZE;
    assign w_cap        = (r_rem > 32'(MAX_BURST)) ? LP_MAX : r_rem[8:0];
    assign w_len        = ({4'b0, w_cap} > w_page_beats) ? w_page_beats[8:0] : w_cap;

    assign w_cmd_acc = (r_state == S_IDLE)  && cmd_valid_i;
    assign w_ar_hs   = (r_state == S_ISSUE) && ar_ready_i;
    assign w_r_acc   = (r_state == S_DATA)  && r_valid_i && out_ready_i;

    // Bad response, r_last on the wrong beat, or the expected final beat
    // arriving without r_last: r_last must coincide with beat_q+1 == burst_q.
    assign w_beat_err = (r_resp_i != 2'b00) || (r_last_i != ((r_beat + 9'd1) == r_burst));

`ifdef AXI_RD_BURST_ABORT_ON_ERR_EN
    assign w_end_cmd = (r_rem == '0) || r_err || w_beat_err;
`else
    assign w_end_cmd = (r_rem == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        cmd_ready_o = 1'b0;
        ar_valid_o  = 1'b0;
        ar_addr_o   = '0;
        ar_len_o    = '0;
        r_ready_o   = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_next = (cmd_beats_i == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                ar_valid_o = 1'b1;
                ar_addr_o  = r_addr;
                ar_len_o   = 8'(w_len - 9'd1);
                if (ar_ready_i) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                r_ready_o   = out_ready_i;
                out_valid_o = r_valid_i;
                out_data_o  = r_data_i;
                out_last_o  = r_last_i && w_end_cmd;
                if (w_r_acc && r_last_i) begin
                    w_next = w_end_cmd ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_addr <= cmd_addr_i;
                r_rem  <= cmd_beats_i;
                r_err  <= 1'b0;
            end
            if (w_ar_hs) begin
                r_burst <= w_len;
                r_addr  <= r_addr + (ADDR_W'(w_len) << SIZE);
                r_rem   <= r_rem - 32'(w_len);
            end
            if (w_r_acc) begin
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
                r_beat <= r_last_i ? '0 : r_beat + 9'd1;
            end
        end
    end

    assign busy_o     = (r_state != S_IDLE);
    assign err_o      = r_err;
    assign ar_id_o    = ID_W'(AXI_ID);
    assign ar_size_o  = 3'(SIZE);
    assign ar_burst_o = 2'b01;

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
module tb_axi_rd_burst_ctrl;

    localparam int unsigned ADDR_W    = 48;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned MAX_BURST = 256;
    localparam int unsigned BPB       = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_beats;
    logic              busy, done, err;
    logic              ar_valid, ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              r_valid, r_ready, r_last;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;

    always #5 clk = ~clk;

    axi_rd_burst_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
        .busy_o(busy), .done_o(done), .err_o(err),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_id_o(ar_id),
        .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
        .r_resp_i(r_resp), .r_last_i(r_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_last_o(out_last)
    );

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference burst plan: split [addr, beats) by MAX_BURST and 4 KiB pages
    logic [ADDR_W-1:0] exp_addr[$];
    int unsigned       exp_len[$];

    task automatic plan(input logic [ADDR_W-1:0] a, input int unsigned beats);
        logic [ADDR_W-1:0] addr;
        int unsigned rem, page, l;
        exp_addr.delete();
        exp_len.delete();
        addr = a;
        rem  = beats;
        while (rem > 0) begin
            page = (4096 - int'(addr % 4096)) / BPB;
            l = rem;
            if (l > MAX_BURST) l = MAX_BURST;
            if (l > page) l = page;
            exp_addr.push_back(addr);
            exp_len.push_back(l);
            addr = addr + ADDR_W'(l * BPB);
            rem  = rem - l;
        end
    endtask

    // Beats the bench slave actually returns for burst i.
    // kind: 0 clean, 1 SLVERR on beat 2, 2 r_last early on beat 3, 3 r_last one beat late
    function automatic int unsigned real_len(input int unsigned i, input int kind, input int unsigned eb);
        int unsigned rl;
        rl = exp_len[i];
        if (kind == 2 && i == eb) rl = 3;
        if (kind == 3 && i == eb) rl = exp_len[i] + 1;
        return rl;
    endfunction

    bit reset_break;

    task automatic run_cmd(input logic [ADDR_W-1:0] a, input int unsigned beats, input int kind,
                           input int unsigned eb, input int rdy_mode, input int unsigned rst_after);
        int unsigned nb_issued, cur, bib, beat_i, cyc, tot_out, exp_total, n_bursts;
        bit active, err_exp, done_seen, fin_next, exp_last, s_arhs, s_racc, s_rlast;
        logic [1:0] s_resp;
        nb_issued = 0; cur = 0; bib = 0; beat_i = 0; cyc = 0; tot_out = 0;
        active = 0; err_exp = 0; done_seen = 0; reset_break = 0;
        plan(a, beats);
        n_bursts = exp_len.size();
`ifdef AXI_RD_BURST_ABORT_ON_ERR_EN
        if (kind != 0 && eb < n_bursts) n_bursts = eb + 1;
`endif
        exp_total = 0;
        for (int unsigned i = 0; i < n_bursts; i++) exp_total += real_len(i, kind, eb);
        fin_next = (beats == 0);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = beats;
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        while (!done_seen && cyc < 20000) begin
            ar_ready  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (active) begin
                r_valid = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                r_data  = {$urandom, $urandom};
                r_resp  = (kind == 1 && cur == eb && beat_i == 1) ? 2'b10 : 2'b00;
                r_last  = (beat_i == bib - 1);
            end else begin
                r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
            end
            #1;
            if (cyc == 0) chk("err_clr_on_accept", err, 0);
            chk("busy", busy, 1);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("done", done, fin_next);
            chk("err", err, err_exp);
            chk("ar_valid", ar_valid, (!active && nb_issued < n_bursts) ? 1 : 0);
            if (ar_valid && nb_issued < exp_len.size()) begin
                chk("ar_addr", ar_addr, exp_addr[nb_issued]);
                chk("ar_len", ar_len, exp_len[nb_issued] - 1);
                chk("ar_id", ar_id, 0);
                chk("ar_size", ar_size, 3);
                chk("ar_burst", ar_burst, 1);
            end
            if (active) begin
                chk("r_ready_mirror", r_ready, out_ready);
                chk("out_valid", out_valid, r_valid);
                if (r_valid && out_ready) begin
                    exp_last = r_last && (cur == n_bursts - 1);
                    chk("out_data", out_data, r_data);
                    chk("out_last", out_last, exp_last);
                end
            end
            if (done) done_seen = 1;
            s_arhs  = ar_valid && ar_ready;
            s_racc  = active && r_valid && r_ready;
            s_rlast = r_last;
            s_resp  = r_resp;
            @(posedge clk);
            fin_next = 0;
            if (s_arhs) begin
                active = 1;
                bib    = real_len(nb_issued, kind, eb);
                beat_i = 0;
                nb_issued++;
            end else if (s_racc) begin
                tot_out++;
                if (s_resp != 2'b00) err_exp = 1;
                if (s_rlast && (beat_i + 1 != exp_len[cur])) err_exp = 1;
                if (!s_rlast && (beat_i + 1 == exp_len[cur])) err_exp = 1;
                beat_i++;
                if (s_rlast) begin
                    active = 0;
                    if (cur == n_bursts - 1) fin_next = 1;
                    cur++;
                end
            end
            @(negedge clk);
            cyc++;
            if (rst_after != 0 && tot_out >= rst_after) begin
                reset_break = 1;
                break;
            end
        end
        if (!reset_break) begin
            chk("done_seen", done_seen, 1);
            chk("beat_total", tot_out, exp_total);
            chk("ar_count", nb_issued, n_bursts);
            r_valid = 1'b0; r_last = 1'b0;
            #1;
            chk("idle_ready", cmd_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("err_held", err, err_exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ar_valid"}, ar_valid, 0);
        chk({tag, "_ar_addr"}, ar_addr, 0);
        chk({tag, "_ar_len"}, ar_len, 0);
        chk({tag, "_r_ready"}, r_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_ar_size"}, ar_size, 3);
        chk({tag, "_ar_burst"}, ar_burst, 1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle_outputs("reset");

        run_cmd(48'h1000, 16, 0, 0, 0, 0);
        run_cmd(48'h0FF0, 8, 0, 0, 0, 0);
        run_cmd(48'h0, 600, 0, 0, 1, 0);
        run_cmd(48'h0, 0, 0, 0, 1, 0);
        run_cmd(48'h2000, 4, 1, 0, 1, 0);
        run_cmd(48'h3000, 4, 2, 0, 1, 0);
        run_cmd(48'h40, 20, 3, 0, 1, 0);
        run_cmd(48'h0, 1024, 1, 0, 1, 0);
        run_cmd(48'h8000, 700, 2, 1, 1, 0);

        // reset in the middle of a data burst
        run_cmd(48'h1000, 16, 0, 0, 1, 5);
        chk("reset_break_reached", reset_break, 1);
        rst = 1'b1;
        r_valid = 1'b1; r_data = {$urandom, $urandom}; r_last = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle_outputs("midrst");
        r_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("midrst_no_done", done, 0);
        end
        run_cmd(48'h1000, 16, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = ADDR_W'($urandom_range(0, 511)) * BPB + ADDR_W'($urandom_range(0, 3)) * 4096;
            run_cmd(ra, $urandom_range(1, 700), 0, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
